// File: rtl/pc_seq_if.sv
// pc_seq_if: control inputs and PC/RAS status bundle for pc_seq.
// master drives control, slave (pc_seq) returns pc and stack status.
interface pc_seq_if #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic             stall;
    logic             branch;
    logic             beq;
    logic             alu_zero;
    logic             jump;
    logic             jal;
    logic             jr;
    logic             ret;
    logic [15:0]      imm16;
    logic [25:0]      target26;
    logic [WIDTH-1:0] reg_target;
    logic             flag_clr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] link_addr;
    logic [CW-1:0]    ras_count;
    logic             ras_ovf;
    logic             ras_unf;

    modport master (
        output stall, branch, beq, alu_zero, jump, jal, jr, ret,
        output imm16, target26, reg_target, flag_clr,
        input  pc, link_addr, ras_count, ras_ovf, ras_unf
    );

    modport slave (
        input  stall, branch, beq, alu_zero, jump, jal, jr, ret,
        input  imm16, target26, reg_target, flag_clr,
        output pc, link_addr, ras_count, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_seq.sv
// pc_seq: program counter sequencer with optional return-address stack.
// Define PC_SEQ_RAS_EN to build the RAS; otherwise ret acts as jr.
module pc_seq #(
    parameter int               WIDTH     = 32,
    parameter int unsigned      INCR      = 1,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               RAS_DEPTH = 4
) (
    input logic     clk,
    input logic     rst_n,
    pc_seq_if.slave bus
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] incr;
    logic [WIDTH-1:0] off;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] j_tgt;
    logic [WIDTH-1:0] ret_tgt;
    logic [WIDTH-1:0] nxt;
    logic             taken;
    logic             sel_ret;
    logic             sel_jr;
    logic             sel_j;
    logic             sel_br;

    assign incr   = pc_q + WIDTH'(INCR);
    assign off    = {{(WIDTH-16){bus.imm16[15]}}, bus.imm16};
    assign br_tgt = incr + off * WIDTH'(INCR);
    assign j_tgt  = {incr[WIDTH-1:26], bus.target26};
    assign taken  = bus.branch & (bus.beq ? bus.alu_zero : !bus.alu_zero);

    // Mutually exclusive selects encode the priority order
    assign sel_ret = bus.ret;
    assign sel_jr  = bus.jr & !bus.ret;
    assign sel_j   = (bus.jump | bus.jal) & !bus.ret & !bus.jr;
    assign sel_br  = taken & !bus.ret & !bus.jr & !bus.jump & !bus.jal;

    always_comb begin
        nxt = incr;
        unique case (1'b1)
            sel_ret: nxt = ret_tgt;
            sel_jr:  nxt = bus.reg_target;
            sel_j:   nxt = j_tgt;
            sel_br:  nxt = br_tgt;
            default: nxt = incr;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (!bus.stall) begin
            pc_q <= nxt;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.link_addr = incr;

`ifdef PC_SEQ_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    sp_q;
    logic [PW-1:0]    top_idx;
    logic [CW-1:0]    cnt_q;
    logic             ovf_q;
    logic             unf_q;
    logic             has;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic             do_repl;
    logic             set_ovf;
    logic             set_unf;

    assign top_idx = sp_q - PW'(1);
    assign has     = cnt_q != '0;
    assign full    = cnt_q == CW'(RAS_DEPTH);
    assign do_repl = bus.jal & bus.ret & has;
    assign do_pop  = bus.ret & has & !bus.jal;
    assign do_push = bus.jal & !(bus.ret & has);
    assign set_unf = bus.ret & !has;
    assign set_ovf = do_push & full;
    assign ret_tgt = has ? ras_mem[top_idx] : bus.reg_target;

    // sp_q is the next free slot; when full it lands on the oldest entry
    always_ff @(posedge clk) begin
        if (!bus.stall) begin
            if (do_push) begin
                ras_mem[sp_q] <= incr;
            end else if (do_repl) begin
                ras_mem[top_idx] <= incr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (!bus.stall) begin
            if (do_push) begin
                sp_q  <= sp_q + PW'(1);
                cnt_q <= full ? cnt_q : cnt_q + CW'(1);
            end else if (do_pop) begin
                sp_q  <= top_idx;
                cnt_q <= cnt_q - CW'(1);
            end
            ovf_q <= set_ovf | (ovf_q & !bus.flag_clr);
            unf_q <= set_unf | (unf_q & !bus.flag_clr);
        end
    end

    assign bus.ras_count = cnt_q;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;
`else
    assign ret_tgt       = bus.reg_target;
    assign bus.ras_count = '0;
    assign bus.ras_ovf   = 1'b0;
    assign bus.ras_unf   = 1'b0;
`endif

endmodule
